// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end with a prefetch queue. It issues word addresses
//   to a synchronous-read instruction memory, whose data arrives one cycle after
//   the address. Fetched words are buffered together with their PC in a
//   DEPTH-entry circular queue. The queue feeds decode through a valid/stall
//   handshake. A branch redirects fetch, flushes the queue and drops any read
//   still in flight.
//
// Ports
//   clk          posedge clock
//   reset        synchronous, active-low reset
//   branch       single-cycle redirect request
//   branch_addr  redirect target
//   stall_i      decode refuses the head entry this cycle
//   next_addr    memory read address (combinational)
//   inst_i       memory data for the address issued the previous cycle
//   v_o          head entry valid
//   inst_o       head instruction (0 when v_o=0)
//   pc_o         head PC (0 when v_o=0)
//   stall_o      queue full
//   count_o      occupied entries
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int                WORD     = 32,
  parameter int                ADDR     = 16,
  parameter int                DEPTH    = 4,
  parameter int                STRIDE   = 1,
  parameter logic [ADDR-1:0]   RESET_PC = {ADDR{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     branch,
  input  logic [ADDR-1:0]          branch_addr,
  input  logic                     stall_i,
  output logic [ADDR-1:0]          next_addr,
  input  logic [WORD-1:0]          inst_i,
  output logic                     v_o,
  output logic [WORD-1:0]          inst_o,
  output logic [ADDR-1:0]          pc_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [ADDR-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  logic [ADDR-1:0] q_pc_q   [DEPTH];
  logic [WORD-1:0] q_inst_q [DEPTH];

  logic [CW-1:0]   occ_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            valid_s;

  // Issue/push/pop decisions and next-state for pointers, count and PC.
  always_comb begin
    next_addr = branch ? branch_addr : pc_q;
    valid_s   = (count_q != {CW{1'b0}});
    // Credit includes the read in flight but ignores a same-cycle pop, so a
    // push can never land on a full queue.
    occ_s     = count_q + CW'(req_q);
    issue_s   = branch | (occ_s < CW'(DEPTH));
    push_s    = req_q & ~branch;
    pop_s     = valid_s & ~stall_i & ~branch;

    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;

    if (issue_s) begin
      req_d    = 1'b1;
      req_pc_d = next_addr;
      pc_d     = next_addr + ADDR'(STRIDE);
    end else begin
      // Unissued cycle: memory output next cycle is ignored, PC frozen.
      req_d    = 1'b0;
    end

    if (branch) begin
      wr_d    = {PW{1'b0}};
      rd_d    = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_d = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= {ADDR{1'b0}};
      wr_q     <= {PW{1'b0}};
      rd_q     <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
    end
  end

  // Queue storage: write the returning word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= {ADDR{1'b0}};
        q_inst_q[i] <= {WORD{1'b0}};
      end
    end else if (push_s) begin
      q_pc_q[wr_q]   <= req_pc_q;
      q_inst_q[wr_q] <= inst_i;
    end else begin
      q_pc_q[wr_q]   <= q_pc_q[wr_q];
      q_inst_q[wr_q] <= q_inst_q[wr_q];
    end
  end

  // Outputs come straight from registered state; no bypass from inst_i.
  always_comb begin
    v_o     = valid_s;
    stall_o = (count_q == CW'(DEPTH));
    count_o = count_q;
    if (valid_s) begin
      inst_o = q_inst_q[rd_q];
      pc_o   = q_pc_q[rd_q];
    end else begin
      inst_o = {WORD{1'b0}};
      pc_o   = {ADDR{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic [15:0] branch_addr;
  logic        stall_i;
  logic [15:0] next_addr;
  logic [31:0] inst_i;
  logic        v_o;
  logic [31:0] inst_o;
  logic [15:0] pc_o;
  logic        stall_o;
  logic [2:0]  count_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: fetch PC, pending read and a queue of PCs.
  logic [15:0] m_pc;
  logic        m_req;
  logic [15:0] m_req_pc;
  logic [15:0] mq[$];
  bit          m_known = 1'b0;

  fetch_queue_unit dut (
    .clk(clk), .reset(reset), .branch(branch), .branch_addr(branch_addr),
    .stall_i(stall_i), .next_addr(next_addr), .inst_i(inst_i), .v_o(v_o),
    .inst_o(inst_o), .pc_o(pc_o), .stall_o(stall_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[a] = A000_0000 | a, one-cycle read.
  always_ff @(posedge clk) inst_i <= 32'hA000_0000 | {16'h0000, next_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input logic [15:0] pc);
    chk("head_v", {31'd0, v_o}, 32'd1);
    chk("head_pc", {16'd0, pc_o}, {16'd0, pc});
    chk("head_inst", inst_o, 32'hA000_0000 | {16'd0, pc});
  endtask

  // One clock: drive inputs, check next_addr, advance model, check outputs.
  task automatic step(input logic rst, input logic b, input logic st, input logic [15:0] ba);
    logic [15:0] na;
    bit          iss;
    @(negedge clk);
    reset = rst; branch = b; stall_i = st; branch_addr = ba;
    #1;
    if (m_known) chk("next_addr", {16'd0, next_addr}, {16'd0, (b ? ba : m_pc)});
    if (!rst) begin
      m_pc = 16'h0000; m_req = 1'b0; mq.delete(); m_known = 1'b1;
    end else begin
      na  = b ? ba : m_pc;
      iss = b || ((mq.size() + int'(m_req)) < 4);
      if (b) mq.delete();
      else begin
        if (mq.size() != 0 && !st) void'(mq.pop_front());
        if (m_req) mq.push_back(m_req_pc);
      end
      if (iss) begin m_req = 1'b1; m_req_pc = na; m_pc = na + 16'd1; end
      else m_req = 1'b0;
    end
    @(posedge clk); #1;
    if (m_known) begin
      chk("v_o", {31'd0, v_o}, {31'd0, (mq.size() != 0)});
      chk("count_o", {29'd0, count_o}, 32'(mq.size()));
      chk("stall_o", {31'd0, stall_o}, {31'd0, (mq.size() == 4)});
      chk("pc_o", {16'd0, pc_o}, (mq.size() != 0) ? {16'd0, mq[0]} : 32'd0);
      chk("inst_o", inst_o, (mq.size() != 0) ? (32'hA000_0000 | {16'd0, mq[0]}) : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; branch = 1'b0; stall_i = 1'b0; branch_addr = 16'h0000;

    // Reset for two cycles, then stream from PC 0.
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_v", {31'd0, v_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("t1_v_early", {31'd0, v_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0001);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0002);

    // Stall six cycles: queue fills, head steady, then resume without gaps.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("t2_count_full", {29'd0, count_o}, 32'd4);
    chk("t2_stall_o", {31'd0, stall_o}, 32'd1);
    head(16'h0002);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0003);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0004);

    // Branch to 0012 with entries queued.
    step(1'b1, 1'b1, 1'b0, 16'h0012);
    chk("t3_v", {31'd0, v_o}, 32'd0);
    chk("t3_count", {29'd0, count_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0012);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0013);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0014);

    // Branch with stall on a full queue.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("t4_full", {31'd0, stall_o}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    chk("t4_count", {29'd0, count_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0040);

    // PC wrap through FFFF.
    step(1'b1, 1'b1, 1'b0, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0001);

    // Reset mid-stream with a read in flight and entries queued.
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("t6_v", {31'd0, v_o}, 32'd0);
    chk("t6_count", {29'd0, count_o}, 32'd0);
    chk("t6_next_addr", {16'd0, next_addr}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("t6_no_stale", {31'd0, v_o}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000); head(16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_b, r_st;
      logic [15:0] r_ba;
      r_rst = ($urandom_range(0, 59) != 0);
      r_b   = ($urandom_range(0, 15) == 0);
      r_st  = ($urandom_range(0, 2) == 0);
      r_ba  = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                          : 16'($urandom);
      step(r_rst, r_b, r_st, r_ba);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
